// File: rtl/audio_clock_regeneration_packet_gen.sv
// HDMI Audio Clock Regeneration packet source.
// Emits N/CTS packets every interval; CTS programmed or measured.
module audio_clock_regeneration_packet_gen #(
   parameter int NW = 20,
   parameter int CW = 20,
   parameter int IW = 20
) (
   input  logic             clk_pixel,
   input  logic             reset,
   input  logic [NW-1:0]    in_N,
   input  logic [CW-1:0]    in_CTS,
   input  logic             in_cts_measure,
   input  logic [IW-1:0]    in_send_interval,
   input  logic             update,
   input  logic             audio_tick,
   output logic             packet_ready,
   input  logic             packet_ack,
   output logic             packet_dropped,
   output logic             cts_overflow,
   output logic             clk_audio_counter_wrap,
   output logic [23:0]      header,
   output logic [3:0][55:0] sub
);

   localparam int TW = NW - 7;

   typedef enum logic {
      WAIT_TICK,
      COUNT
   } mstate_t;

   logic [NW-1:0] r_n;
   logic [CW-1:0] r_cts;
   logic          r_mode;
   logic [IW-1:0] r_interval;
   logic [IW-1:0] r_icnt;

   mstate_t       r_mstate;
   mstate_t       w_mstate_nxt;
   logic [CW-1:0] r_cyc;
   logic [TW-1:0] r_ticks;
   logic [CW-1:0] r_meas_cts;
   logic          r_meas_valid;
   logic          r_ovf;

   logic          r_ready;
   logic          r_dropped;
   logic          r_wrap;
   logic [NW-1:0] r_pkt_n;
   logic [CW-1:0] r_pkt_cts;

   logic          w_valid;
   logic          w_measure;
   logic          w_expire;
   logic          w_fire;
   logic          w_cyc_max;
   logic [CW-1:0] w_cyc_inc;
   logic          w_tick_done;
   logic [CW-1:0] w_cts_src;
   logic [19:0]   w_pn;
   logic [19:0]   w_pc;
   logic [55:0]   w_sp;

   assign w_valid = (r_n != '0) && (r_interval != '0) &&
                    (r_mode ? (r_n[6:0] == 7'd0) : (r_cts != '0));
   assign w_measure = w_valid && r_mode;
   assign w_expire = w_valid && (r_icnt == r_interval - IW'(1));
   // With no finished measurement the expiry still wraps but sends nothing
   assign w_fire = w_expire && !update && (!r_mode || r_meas_valid);
   assign w_cts_src = r_mode ? r_meas_cts : r_cts;

   assign w_cyc_max = &r_cyc;
   assign w_cyc_inc = w_cyc_max ? r_cyc : r_cyc + CW'(1);
   assign w_tick_done = (r_ticks + TW'(1)) == r_n[NW-1:7];

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         r_n        <= '0;
         r_cts      <= '0;
         r_mode     <= 1'b0;
         r_interval <= '0;
      end else if (update) begin
         r_n        <= in_N;
         r_cts      <= in_CTS;
         r_mode     <= in_cts_measure;
         r_interval <= in_send_interval;
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) r_mstate <= WAIT_TICK;
      else       r_mstate <= w_mstate_nxt;
   end

   always_comb begin
      w_mstate_nxt = r_mstate;
      unique case (r_mstate)
         WAIT_TICK: if (audio_tick) w_mstate_nxt = COUNT;
         COUNT:     w_mstate_nxt = COUNT;
      endcase
      if (update || !w_measure) w_mstate_nxt = WAIT_TICK;
   end

   // Window closes on the N/128-th tick, counting the closing cycle
   always_ff @(posedge clk_pixel) begin
      if (reset || update) begin
         r_cyc        <= '0;
         r_ticks      <= '0;
         r_meas_cts   <= '0;
         r_meas_valid <= 1'b0;
         r_ovf        <= 1'b0;
      end else if (!w_measure || r_mstate == WAIT_TICK) begin
         r_cyc   <= '0;
         r_ticks <= '0;
      end else begin
         if (w_cyc_max) r_ovf <= 1'b1;
         if (audio_tick && w_tick_done) begin
            r_meas_cts   <= w_cyc_inc;
            r_meas_valid <= 1'b1;
            r_cyc        <= '0;
            r_ticks      <= '0;
         end else begin
            r_cyc <= w_cyc_inc;
            if (audio_tick) r_ticks <= r_ticks + TW'(1);
         end
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (reset || update || !w_valid || w_expire) r_icnt <= '0;
      else                                         r_icnt <= r_icnt + IW'(1);
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         r_ready   <= 1'b0;
         r_dropped <= 1'b0;
         r_wrap    <= 1'b0;
         r_pkt_n   <= '0;
         r_pkt_cts <= '0;
      end else begin
         r_dropped <= 1'b0;
         if (w_fire) begin
            r_wrap    <= ~r_wrap;
            r_pkt_n   <= r_n;
            r_pkt_cts <= w_cts_src;
            r_ready   <= 1'b1;
            r_dropped <= r_ready && !packet_ack;
         end else if (packet_ack) begin
            r_ready <= 1'b0;
         end
      end
   end

   assign w_pn = 20'(r_pkt_n);
   assign w_pc = 20'(r_pkt_cts);
   assign w_sp = {w_pn[7:0], w_pn[15:8], 4'd0, w_pn[19:16],
                  w_pc[7:0], w_pc[15:8], 4'd0, w_pc[19:16], 8'd0};

   assign sub                    = {4{w_sp}};
   assign header                 = {8'd0, 8'd0, 8'd1};
   assign packet_ready           = r_ready;
   assign packet_dropped         = r_dropped;
   assign cts_overflow           = r_ovf;
   assign clk_audio_counter_wrap = r_wrap;

endmodule

// File: tb/tb_audio_clock_regeneration_packet_gen.sv
// Bench for the ACR packet source: scenario tasks checked
// against arithmetic expectations and a per-cycle handshake model.
module tb_audio_clock_regeneration_packet_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic             reset = 1'b1;
   logic [19:0]      in_N = '0;
   logic [19:0]      in_CTS = '0;
   logic             in_cts_measure = 1'b0;
   logic [19:0]      in_send_interval = '0;
   logic             update = 1'b0;
   logic             audio_tick = 1'b0;
   logic             packet_ack = 1'b0;
   logic             packet_ready;
   logic             packet_dropped;
   logic             cts_overflow;
   logic             wrap;
   logic [23:0]      header;
   logic [3:0][55:0] sub;

   logic [19:0]      b_N = '0;
   logic [7:0]       b_CTS = '0;
   logic             b_meas = 1'b0;
   logic [19:0]      b_iv = '0;
   logic             b_update = 1'b0;
   logic             b_tick = 1'b0;
   logic             b_ack = 1'b0;
   logic             b_ready;
   logic             b_drop;
   logic             b_ovf;
   logic             b_wrap;
   logic [23:0]      b_header;
   logic [3:0][55:0] b_sub;

   audio_clock_regeneration_packet_gen dut (
      .clk_pixel              (clk),
      .reset                  (reset),
      .in_N                   (in_N),
      .in_CTS                 (in_CTS),
      .in_cts_measure         (in_cts_measure),
      .in_send_interval       (in_send_interval),
      .update                 (update),
      .audio_tick             (audio_tick),
      .packet_ready           (packet_ready),
      .packet_ack             (packet_ack),
      .packet_dropped         (packet_dropped),
      .cts_overflow           (cts_overflow),
      .clk_audio_counter_wrap (wrap),
      .header                 (header),
      .sub                    (sub)
   );

   audio_clock_regeneration_packet_gen #(.NW(20), .CW(8), .IW(20)) dut8 (
      .clk_pixel              (clk),
      .reset                  (reset),
      .in_N                   (b_N),
      .in_CTS                 (b_CTS),
      .in_cts_measure         (b_meas),
      .in_send_interval       (b_iv),
      .update                 (b_update),
      .audio_tick             (b_tick),
      .packet_ready           (b_ready),
      .packet_ack             (b_ack),
      .packet_dropped         (b_drop),
      .cts_overflow           (b_ovf),
      .clk_audio_counter_wrap (b_wrap),
      .header                 (b_header),
      .sub                    (b_sub)
   );

   function automatic logic [55:0] pkt(input logic [19:0] n,
                                       input logic [19:0] c);
      return {n[7:0], n[15:8], 4'd0, n[19:16],
              c[7:0], c[15:8], 4'd0, c[19:16], 8'd0};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      packet_ack = 1'b0;
      audio_tick = 1'b0;
      b_ack = 1'b0;
      b_tick = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic do_update(input logic [19:0] n, input logic [19:0] c,
                            input logic m, input logic [19:0] iv);
      in_N = n;
      in_CTS = c;
      in_cts_measure = m;
      in_send_interval = iv;
      update = 1'b1;
      step();
      update = 1'b0;
   endtask

   task automatic test_reset();
      int seen;
      reset = 1'b1;
      step();
      step();
      tests++;
      if ({packet_ready, packet_dropped, cts_overflow, wrap} !== 4'b0) begin
         fails++;
         $display("FAIL reset_flags got %b want 0000",
                  {packet_ready, packet_dropped, cts_overflow, wrap});
      end
      tests++;
      if (sub !== '0) begin
         fails++;
         $display("FAIL reset_sub got %h want 0", sub);
      end
      tests++;
      if (header !== 24'h000001) begin
         fails++;
         $display("FAIL reset_header got %h want 000001", header);
      end
      tests++;
      if ({b_ready, b_ovf, b_wrap} !== 3'b0) begin
         fails++;
         $display("FAIL reset_dut8 got %b want 000", {b_ready, b_ovf, b_wrap});
      end
      reset = 1'b0;
      seen = 0;
      for (int t = 0; t < 20; t++) begin
         step();
         if (packet_ready) seen++;
      end
      tests++;
      if (seen != 0) begin
         fails++;
         $display("FAIL reset_idle ready_cycles got %0d want 0", seen);
      end
   endtask

   task automatic test_programmed();
      int first;
      int nwrap;
      int bad_wrap;
      logic prev;
      logic [55:0] exp0;
      apply_reset();
      exp0 = {8'h00, 8'h18, 8'h00, 8'h0A, 8'h22, 8'h01, 8'h00};
      do_update(20'd6144, 20'd74250, 1'b0, 20'd1000);
      first = -1;
      nwrap = 0;
      bad_wrap = 0;
      prev = 1'b0;
      for (int t = 1; t <= 2000; t++) begin
         step();
         if (packet_ready && first < 0) first = t;
         if (wrap !== prev) begin
            nwrap++;
            if (t % 1000 != 0) bad_wrap++;
            prev = wrap;
         end
      end
      tests++;
      if (first != 1000) begin
         fails++;
         $display("FAIL prog_first_ready got %0d want 1000", first);
      end
      tests++;
      if (sub[0] !== exp0) begin
         fails++;
         $display("FAIL prog_sub0 got %h want %h", sub[0], exp0);
      end
      tests++;
      if (sub[3] !== exp0) begin
         fails++;
         $display("FAIL prog_sub3 got %h want %h", sub[3], exp0);
      end
      tests++;
      if (nwrap != 2 || bad_wrap != 0) begin
         fails++;
         $display("FAIL prog_wrap toggles got %0d/%0d off-period want 2/0",
                  nwrap, bad_wrap);
      end
      packet_ack = 1'b1;
      step();
      packet_ack = 1'b0;
      tests++;
      if (packet_ready !== 1'b0) begin
         fails++;
         $display("FAIL prog_ack got %b want 0", packet_ready);
      end
   endtask

   task automatic test_handshake();
      logic er;
      logic ed;
      apply_reset();
      do_update(20'd6144, 20'd1000, 1'b0, 20'd10);
      for (int t = 1; t <= 60; t++) begin
         packet_ack = (t == 50) || (t == 53) || (t == 55);
         step();
         packet_ack = 1'b0;
         ed = (t >= 20 && t <= 40 && t % 10 == 0);
         er = (t >= 10 && t < 53) || (t >= 60);
         tests++;
         if ({packet_ready, packet_dropped} !== {er, ed}) begin
            fails++;
            $display("FAIL handshake t=%0d ready/drop got %b%b want %b%b",
                     t, packet_ready, packet_dropped, er, ed);
         end
      end
   endtask

   task automatic test_random_programmed();
      logic [19:0] n;
      logic [19:0] c;
      int iv;
      logic ack;
      logic er;
      logic ed;
      logic ew;
      logic [55:0] ep;
      for (int r = 0; r < 3; r++) begin
         apply_reset();
         n = 20'($urandom_range(1, 20'hFFFFF));
         c = 20'($urandom_range(1, 20'hFFFFF));
         iv = $urandom_range(2, 40);
         do_update(n, c, 1'b0, 20'(iv));
         er = 1'b0;
         ed = 1'b0;
         ew = 1'b0;
         ep = '0;
         for (int t = 1; t <= 6 * iv + 3; t++) begin
            ack = ($urandom_range(0, 3) == 0);
            packet_ack = ack;
            step();
            packet_ack = 1'b0;
            if (t % iv == 0) begin
               ed = er && !ack;
               er = 1'b1;
               ew = ~ew;
               ep = pkt(n, c);
            end else begin
               ed = 1'b0;
               if (ack) er = 1'b0;
            end
            tests++;
            if ({packet_ready, packet_dropped, wrap, sub[t % 4]} !==
                {er, ed, ew, ep}) begin
               fails++;
               $display("FAIL rand r=%0d t=%0d got %b%b%b %h want %b%b%b %h",
                        r, t, packet_ready, packet_dropped, wrap, sub[t % 4],
                        er, ed, ew, ep);
            end
         end
      end
   endtask

   task automatic test_measured();
      int t0;
      int close;
      int exp_first;
      int first;
      t0 = $urandom_range(1, 50);
      close = t0 + 48 * 1547;
      exp_first = (close / 1000 + 1) * 1000;
      apply_reset();
      do_update(20'd6144, 20'd12345, 1'b1, 20'd1000);
      first = -1;
      for (int t = 1; t <= exp_first + 5; t++) begin
         audio_tick = (t >= t0) && ((t - t0) % 1547 == 0);
         step();
         if (packet_ready && first < 0) first = t;
      end
      audio_tick = 1'b0;
      tests++;
      if (first != exp_first) begin
         fails++;
         $display("FAIL meas_first_ready got %0d want %0d", first, exp_first);
      end
      tests++;
      if (sub[1] !== pkt(20'd6144, 20'(48 * 1547))) begin
         fails++;
         $display("FAIL meas_cts got %h want %h", sub[1],
                  pkt(20'd6144, 20'(48 * 1547)));
      end
      tests++;
      if (cts_overflow !== 1'b0) begin
         fails++;
         $display("FAIL meas_overflow got %b want 0", cts_overflow);
      end
      tests++;
      if (wrap !== 1'b1) begin
         fails++;
         $display("FAIL meas_wrap got %b want 1", wrap);
      end
   endtask

   task automatic test_overflow();
      int first;
      apply_reset();
      b_N = 20'd128;
      b_CTS = 8'd0;
      b_meas = 1'b1;
      b_iv = 20'd100;
      b_update = 1'b1;
      step();
      b_update = 1'b0;
      first = -1;
      for (int t = 1; t <= 400; t++) begin
         b_tick = (t >= 5) && ((t - 5) % 300 == 0);
         step();
         if (b_ready && first < 0) first = t;
      end
      b_tick = 1'b0;
      tests++;
      if (b_ovf !== 1'b1) begin
         fails++;
         $display("FAIL ovf_flag got %b want 1", b_ovf);
      end
      tests++;
      if (first != 400) begin
         fails++;
         $display("FAIL ovf_first_ready got %0d want 400", first);
      end
      tests++;
      if (b_sub[2] !== pkt(20'd128, 20'd255)) begin
         fails++;
         $display("FAIL ovf_cts got %h want %h", b_sub[2],
                  pkt(20'd128, 20'd255));
      end
      b_update = 1'b1;
      step();
      b_update = 1'b0;
      tests++;
      if (b_ovf !== 1'b0) begin
         fails++;
         $display("FAIL ovf_clear got %b want 0", b_ovf);
      end
   endtask

   task automatic test_invalid();
      logic [19:0] n;
      logic [19:0] c;
      logic m;
      int seen;
      int first;
      int held;
      apply_reset();
      for (int k = 0; k < 3; k++) begin
         n = (k == 0) ? 20'd0 : (k == 1) ? 20'd100 : 20'd6144;
         c = (k == 2) ? 20'd0 : 20'd5000;
         m = (k == 1);
         do_update(n, c, m, 20'd10);
         seen = 0;
         for (int t = 1; t <= 50; t++) begin
            audio_tick = (t % 3 == 0);
            step();
            if (packet_ready || wrap) seen++;
         end
         audio_tick = 1'b0;
         tests++;
         if (seen != 0) begin
            fails++;
            $display("FAIL invalid_cfg%0d active_cycles got %0d want 0", k, seen);
         end
      end
      do_update(20'd6144, 20'd5000, 1'b0, 20'd10);
      first = -1;
      for (int t = 1; t <= 10; t++) begin
         step();
         if (packet_ready && first < 0) first = t;
      end
      tests++;
      if (first != 10) begin
         fails++;
         $display("FAIL invalid_resume got %0d want 10", first);
      end
      do_update(20'd0, 20'd5000, 1'b0, 20'd10);
      held = 0;
      for (int t = 1; t <= 30; t++) begin
         step();
         if (packet_ready) held++;
      end
      tests++;
      if (held != 30 || sub[0] !== pkt(20'd6144, 20'd5000)) begin
         fails++;
         $display("FAIL invalid_pending held got %0d sub %h want 30 %h",
                  held, sub[0], pkt(20'd6144, 20'd5000));
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      apply_reset();
      do_update(20'd6144, 20'd5000, 1'b0, 20'd10);
      for (int t = 1; t <= 12; t++) step();
      tests++;
      if ({packet_ready, wrap} !== 2'b11) begin
         fails++;
         $display("FAIL midreset_pre got %b%b want 11", packet_ready, wrap);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      tests++;
      if ({packet_ready, packet_dropped, wrap} !== 3'b0 || sub !== '0) begin
         fails++;
         $display("FAIL midreset_state got %b%b%b %h want 000 0",
                  packet_ready, packet_dropped, wrap, sub[0]);
      end
      seen = 0;
      for (int t = 1; t <= 30; t++) begin
         step();
         if (packet_ready || wrap) seen++;
      end
      tests++;
      if (seen != 0) begin
         fails++;
         $display("FAIL midreset_idle got %0d want 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_programmed();
      test_handshake();
      test_random_programmed();
      test_measured();
      test_overflow();
      test_invalid();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/audio_clock_regeneration_packet_gen.md
Name: audio_clock_regeneration_packet_gen

Overview:
- Parametrised next-generation HDMI Audio Clock Regeneration (ACR) packet source, per HDMI 1.4b section 5.3.3.
- Emits one ACR packet request every programmable number of TMDS clocks, with a ready/ack handshake to the packet scheduler.
- Supplies CTS either from a programmed value or from hardware measurement of TMDS cycles against an audio sample strobe.
- Sits beside the audio sample packet source and feeds the data-island packet mux.

Parameters:
- NW, 20, width of N field; must be 20 for spec-compliant packets.
- CW, 20, width of CTS field and of the CTS measurement counter.
- IW, 20, width of the send-interval counter.

Ports:
- clk_pixel  input  1  TMDS/pixel clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- in_N  input  NW  requested N value.
- in_CTS  input  CW  programmed CTS, used when in_cts_measure=0.
- in_cts_measure  input  1  0: programmed CTS; 1: measured CTS.
- in_send_interval  input  IW  TMDS clocks between packets.
- update  input  1  one-cycle strobe; latches the in_* values.
- audio_tick  input  1  one-cycle strobe at fs, already in the clk_pixel domain.
- packet_ready  output  1  a packet is pending.
- packet_ack  input  1  the scheduler consumes the pending packet this cycle.
- packet_dropped  output  1  one-cycle pulse when a pending packet is overwritten.
- cts_overflow  output  1  sticky flag: the measurement counter saturated.
- clk_audio_counter_wrap  output  1  toggles on each interval expiry.
- header  output  24  {8'd0, 8'd0, 8'd1}.
- sub  output  4x56  four identical subpackets.

Behaviour:
- Reset values:
  - All config registers = 0.
  - Interval and measurement counters = 0.
  - packet_ready = 0, packet_dropped = 0, cts_overflow = 0, clk_audio_counter_wrap = 0.
  - Packet N/CTS registers = 0.
- Config latch: on update, register N, CTS, mode and interval. The interval counter and measurement state restart at 0 on the next cycle. cts_overflow clears on update.
- Config validity:
  - Invalid if N=0, interval=0, or (mode=programmed and CTS=0), or (mode=measured and N[6:0]!=0, i.e. N not a multiple of 128).
  - While invalid: state IDLE, no packets, counters held at 0. A packet already pending stays pending until acked.
- Interval counter:
  - In RUN it increments every cycle.
  - When counter == interval-1 (expiry): counter goes to 0, clk_audio_counter_wrap toggles, and the packet registers load {N, CTS_src}.
  - Period is therefore exactly interval cycles.
- CTS_src selection:
  - Programmed mode: latched CTS.
  - Measured mode: last completed measurement. If no measurement has completed since config, expiry is skipped (no packet, no toggle); the counter still wraps.
- Measurement FSM (measured mode only):
  - States WAIT_TICK, COUNT.
  - WAIT_TICK → COUNT on the first audio_tick; cycle count = 0, tick count = 0.
  - In COUNT, every cycle increments the cycle count, saturating at 2^CW-1. Saturation sets cts_overflow.
  - Each audio_tick increments the tick count. On the tick that makes the tick count equal N>>7, the measured CTS = cycle count + 1 (the window includes the closing cycle); cycle count and tick count restart at 0 and the FSM stays in COUNT.
  - So CTS = TMDS cycles per N/128 audio samples.
- Handshake:
  - Expiry sets packet_ready; packet_ready clears on packet_ack.
  - Expiry while packet_ready=1 and no ack: packet contents are overwritten, packet_dropped pulses and packet_ready stays 1.
  - Expiry and ack in the same cycle: the old packet is consumed, new contents load, packet_ready stays 1, no drop.
  - packet_ack while packet_ready=0 is ignored.
  - Contents are stable while packet_ready=1 except on an overwrite.
- Packet format: each sub[i] = {N[7:0], N[15:8], {4'd0, N[19:16]}, CTS[7:0], CTS[15:8], {4'd0, CTS[19:16]}, 8'd0} from the packet registers.
- Reset mid-operation: immediate return to the reset values on the next edge; any pending packet is discarded.

Test Plan:
- Programmed mode: update with N=6144, CTS=74250, interval=1000 → packet_ready first rises 1000 cycles after update; sub[0] = {8'h00, 8'h18, 8'h00, 8'h0A, 8'h22, 8'h01, 8'h00}; the wrap output toggles every 1000 cycles.
- Handshake: never ack, interval=10 → packet_dropped pulses every 10 cycles after the first packet. Ack in the expiry cycle → no drop, packet_ready stays 1.
- Measured mode: N=6144 (48 ticks), audio_tick every 1547 cycles → first packet only after a measurement completes; CTS = 74256 (48 × 1547). cts_overflow stays 0.
- Overflow: CW=8, measured mode, N=128, tick every 300 cycles → cts_overflow sets; CTS = 255.
- Invalid config: N=0, or N=100 in measured mode → no packet_ready within 5 × interval. A valid update resumes packets.
- Reset asserted for 1 cycle while packet_ready=1 → the next cycle shows packet_ready=0, wrap=0, and all counters at 0.
